rca_result_accumulator: RTL
===========================

RCA_RESULT_ACCUMULATOR -- requirements
Module: rca_result_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand width of the upstream ripple-carry adder; results arrive as WIDTH+1 bits.
REQ-002 The block SHALL have parameter COUNT, default 8: number of accepted results per block.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 20: accumulator width.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port i_flush, input, 1 bit: synchronous abort of the current block.
REQ-007 The block SHALL have port i_result, input, WIDTH+1 bits: adder result ({carry, sum}).
REQ-008 The block SHALL have port i_valid, input, 1 bit: i_result and i_last are valid.
REQ-009 The block SHALL have port i_last, input, 1 bit: the current beat terminates the block early.
REQ-010 The block SHALL have port o_ready, output, 1 bit: the block can accept a beat.
REQ-011 The block SHALL have port o_sum, output, ACC_WIDTH bits: accumulated block sum.
REQ-012 The block SHALL have port o_count, output, $clog2(COUNT+1) bits: number of beats in the presented sum.
REQ-013 The block SHALL have port o_ovf, output, 1 bit: the accumulator wrapped during this block.
REQ-014 The block SHALL have port o_valid, output, 1 bit: o_sum, o_count and o_ovf are valid.
REQ-015 The block SHALL have port i_ready, input, 1 bit: downstream accepts the result.

Function
REQ-016 The block SHALL implement a three-state FSM with states IDLE (no beats), ACCUM (1..COUNT-1 beats taken) and HOLD (result presented).
REQ-017 o_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD; it SHALL be a registered/state-decoded value with no combinational path from i_ready.
REQ-018 A beat SHALL be accepted on a rising edge where i_valid=1 and o_ready=1; the accumulator then becomes acc + zero-extended i_result, modulo 2^ACC_WIDTH, and the beat count increments.
REQ-019 If an accepted addition carries out of ACC_WIDTH bits, a sticky ovf bit SHALL be set for the block.
REQ-020 Transitions SHALL be: IDLE->ACCUM on an accepted beat; IDLE/ACCUM->HOLD on an accepted beat that has i_last=1 or that makes the count equal to COUNT; HOLD->IDLE on a rising edge where o_valid=1 and i_ready=1.
REQ-021 Latency SHALL be 1 cycle: o_valid asserts on the cycle after the final beat is accepted, with o_sum including that beat.
REQ-022 In HOLD, o_sum, o_count and o_ovf SHALL stay stable while o_valid=1 and i_ready=0.
REQ-023 On the HOLD->IDLE handshake, the accumulator, count and ovf SHALL clear; o_ready SHALL be 1 on the next cycle, giving no back-to-back overlap of blocks (one bubble cycle per block).
REQ-024 o_sum, o_count and o_ovf SHALL read 0 whenever o_valid=0.
REQ-025 i_flush=1 SHALL clear the accumulator, count and ovf and force IDLE on the same edge from any state, discarding a held result; a beat presented in the same cycle SHALL be dropped.
REQ-026 i_last=1 on a beat that also reaches COUNT SHALL produce a single HOLD entry.
REQ-027 i_last is ignored when i_valid=0; beats with i_valid=1 while o_ready=0 are not consumed.
REQ-028 The block SHALL require ACC_WIDTH >= WIDTH+1 and COUNT >= 1; with ACC_WIDTH >= WIDTH+1+$clog2(COUNT), o_ovf can never assert.

Reset
REQ-029 i_rst=1 SHALL on the next edge force IDLE, clear the accumulator, count and ovf, and set o_valid=0, o_ready=1, o_sum=0, o_count=0, o_ovf=0.
REQ-030 Reset SHALL take priority over i_flush and beat acceptance, including mid-block and in HOLD.

Verification
REQ-031 Full block: 8 beats of i_result=17'h1FFFE, i_ready=1 -> one cycle after beat 8: o_valid=1, o_sum=20'hFFFF0, o_count=8, o_ovf=0; o_ready=1 two cycles after beat 8.
REQ-032 Early termination: beats 17'h00005 and 17'h0000A (i_last on the second) -> o_sum=15, o_count=2.
REQ-033 Backpressure: i_ready=0 for 5 cycles after o_valid -> o_sum stable, o_ready=0, extra i_valid beats not consumed; release i_ready -> IDLE next cycle.
REQ-034 Overflow: ACC_WIDTH=18, three beats of 17'h1FFFF with i_last on the third -> o_sum=18'h1FFFD, o_ovf=1, o_count=3.
REQ-035 Flush and reset: i_flush after 3 beats -> IDLE, count 0, and the next block's sum excludes prior beats; i_rst asserted in HOLD -> o_valid=0 on the next edge, with all outputs at their reset values.

Source files
------------

// File: rtl/rca_result_accumulator.sv
// Accumulates ripple-carry adder results into per-block sums of up to COUNT beats,
// presenting each sum with a beat count and sticky wrap flag through a valid/ready handshake.
module rca_result_accumulator #(
    parameter int WIDTH     = 16,
    parameter int COUNT     = 8,
    parameter int ACC_WIDTH = 20
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,
    input  logic [WIDTH:0]               i_result,
    input  logic                         i_valid,
    input  logic                         i_last,
    output logic                         o_ready,
    output logic [ACC_WIDTH-1:0]         o_sum,
    output logic [$clog2(COUNT+1)-1:0]   o_count,
    output logic                         o_ovf,
    output logic                         o_valid,
    input  logic                         i_ready
);

    localparam int CW = $clog2(COUNT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              r_state;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [CW-1:0]        r_count;
    logic                 r_ovf;
    logic                 r_valid;
    logic                 r_ready;

    logic [ACC_WIDTH:0]   w_sum_ext;
    logic                 w_carry;
    logic [CW-1:0]        w_count_nxt;
    logic                 w_accept;
    logic                 w_done;

    // One extra bit catches the carry out of the accumulator for the sticky wrap flag.
    assign w_sum_ext   = {1'b0, r_acc} + {{(ACC_WIDTH - WIDTH){1'b0}}, i_result};
    assign w_carry     = w_sum_ext[ACC_WIDTH];
    assign w_count_nxt = r_count + CW'(1);
    assign w_accept    = i_valid && r_ready;
    assign w_done      = i_last || (w_count_nxt == CW'(COUNT));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= w_sum_ext[ACC_WIDTH-1:0];
                        r_count <= w_count_nxt;
                        r_ovf   <= r_ovf | w_carry;
                        if (w_done) begin
                            r_state <= HOLD;
                            r_valid <= 1'b1;
                            r_ready <= 1'b0;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        r_state <= IDLE;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_acc   <= '0;
                    r_count <= '0;
                    r_ovf   <= 1'b0;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_sum   = r_valid ? r_acc   : '0;
    assign o_count = r_valid ? r_count : '0;
    assign o_ovf   = r_valid ? r_ovf   : 1'b0;

endmodule
